// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: shared definitions for the PWM chain sequencer.
//   seq_state_t     - sequencer FSM states (IDLE, STAGGER, RUNNING, DRAIN)
//   ELAPSED_SAT_ALL - all-ones pattern; the top slices it to SHIFT_WIDTH bits
//                     to get the elapsed-counter saturation value (so
//                     SHIFT_WIDTH may be at most 64).
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STAGGER = 2'd1,
        RUNNING = 2'd2,
        DRAIN   = 2'd3
    } seq_state_t;

    localparam logic [63:0] ELAPSED_SAT_ALL = '1;

endpackage

// File: rtl/pwm_chain_sequencer.sv
// pwm_chain_sequencer: starts N_CHAINS PWM counters with per-chain delays
// (phase-staggered carriers) and stops each one only at its own period end.
//
// Optional feature macro: PWM_SEQ_DRAIN_TIMEOUT_EN
//   defined   - chains that never report period_end are forced off
//               DRAIN_TIMEOUT cycles after entering DRAIN; timeout_error is set.
//   undefined - DRAIN waits indefinitely; timeout_error is tied low.
//
// Ports:
//   clock, reset        - single clock, asynchronous active-high reset
//   start, stop         - single-cycle requests
//   timebase_shift[k]   - start delay of chain k (latched on start)
//   period_end[k]       - single-cycle period-end pulse from chain k
//   chain_enable[k]     - counter enable of chain k
//   counter_running[k]  - copy of chain_enable for the chain control units
//   busy                - high in STAGGER and DRAIN
//   update_strobe       - one-cycle pulse on DRAIN -> IDLE (or direct stop-to-IDLE)
//   timeout_error       - sticky drain timeout flag, cleared on start
//   seq_state           - current FSM state, for observation
//
// Request semantics: start/stop are plain one-cycle pulses with no
// handshake; a request is acted on only in the states that accept it and is
// otherwise dropped. All outputs come straight from registers.
module pwm_chain_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int N_CHAINS      = 3,
    parameter int SHIFT_WIDTH   = 16,
    parameter int DRAIN_TIMEOUT = 65535
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   stop,
    input  logic [N_CHAINS-1:0][SHIFT_WIDTH-1:0]   timebase_shift,
    input  logic [N_CHAINS-1:0]                    period_end,
    output logic [N_CHAINS-1:0]                    chain_enable,
    output logic [N_CHAINS-1:0]                    counter_running,
    output logic                                   busy,
    output logic                                   update_strobe,
    output logic                                   timeout_error,
    output seq_state_t                             seq_state
);

    localparam logic [SHIFT_WIDTH-1:0] ELAPSED_SAT = ELAPSED_SAT_ALL[SHIFT_WIDTH-1:0];

    seq_state_t                          state_q, state_d;
    logic [N_CHAINS-1:0][SHIFT_WIDTH-1:0] shadow_shift;
    logic [SHIFT_WIDTH-1:0]              elapsed;
    logic [N_CHAINS-1:0]                 en_q, en_d, pe_q, fire, drop;
    logic                                strobe_q, strobe_d;
    logic                                timeout_q;
    logic                                expire;

    // Per-chain enable. A chain fires when the elapsed count matches its
    // shadow shift, unless stop arrives in that same cycle (stop wins, and a
    // chain still waiting is never enabled). period_end is registered once
    // (pe_q) so the enable drops one edge after the pulse is sampled.
    for (genvar k = 0; k < N_CHAINS; k++) begin : g_chain
        assign fire[k] = (state_q == STAGGER) && !stop && (elapsed == shadow_shift[k]);
        assign drop[k] = (state_q == DRAIN) && (pe_q[k] || expire);
        assign en_d[k] = (en_q[k] | fire[k]) & ~drop[k];
    end

    always_comb begin
        state_d  = state_q;
        strobe_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = STAGGER;
            end
            STAGGER: begin
                if (stop) begin
                    // Nothing enabled yet: no chain to drain.
                    if (en_q == '0) begin
                        state_d  = IDLE;
                        strobe_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (&en_d) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (stop) state_d = DRAIN;
            end
            DRAIN: begin
                if (en_d == '0) begin
                    state_d  = IDLE;
                    strobe_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            strobe_q     <= 1'b0;
            en_q         <= '0;
            pe_q         <= '0;
            shadow_shift <= '0;
            elapsed      <= '0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            en_q     <= en_d;
            pe_q     <= period_end;
            if (state_q == IDLE && start) begin
                shadow_shift <= timebase_shift;
                elapsed      <= '0;
            end else if (state_q == STAGGER && elapsed != ELAPSED_SAT) begin
                elapsed <= elapsed + 1'b1;
            end
        end
    end

`ifdef PWM_SEQ_DRAIN_TIMEOUT_EN
    // All chains enter DRAIN on the same edge, so one shared counter gives
    // every chain the same deadline.
    logic [31:0] drain_cnt;

    assign expire = (state_q == DRAIN) && (drain_cnt == 32'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drain_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q != DRAIN)
                drain_cnt <= '0;
            else if (!expire)
                drain_cnt <= drain_cnt + 32'd1;

            if (state_q == IDLE && start)
                timeout_q <= 1'b0;
            else if (expire && |(en_q & ~pe_q))
                timeout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_param;
    assign unused_timeout_param = |DRAIN_TIMEOUT;
    assign expire    = 1'b0;
    assign timeout_q = 1'b0;
`endif

    assign chain_enable    = en_q;
    assign counter_running = en_q;
    assign busy            = (state_q == STAGGER) || (state_q == DRAIN);
    assign update_strobe   = strobe_q;
    assign timeout_error   = timeout_q;
    assign seq_state       = state_q;

endmodule

// File: tb/tb_pwm_chain_sequencer.sv
// Testbench for pwm_chain_sequencer: table of start/stop scenarios with
// hand-computed enable edges, plus directed sequences for staggered drain,
// request priorities, asynchronous reset and (when the feature macro is
// defined) drain timeout.
module tb_pwm_chain_sequencer;
    import pwm_seq_pkg::*;

    localparam int N = 3;
    localparam int W = 16;
    localparam logic [7:0] NEVER = 8'hFF;

    logic               clock;
    logic               reset;
    logic               start;
    logic               stop;
    logic [N-1:0][W-1:0] timebase_shift;
    logic [N-1:0]       period_end;
    logic [N-1:0]       chain_enable;
    logic [N-1:0]       counter_running;
    logic               busy;
    logic               update_strobe;
    logic               timeout_error;
    seq_state_t         seq_state;

    int n_checks = 0;
    int n_errors = 0;

    pwm_chain_sequencer #(
        .N_CHAINS     (N),
        .SHIFT_WIDTH  (W),
        .DRAIN_TIMEOUT(100)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .timebase_shift (timebase_shift),
        .period_end     (period_end),
        .chain_enable   (chain_enable),
        .counter_running(counter_running),
        .busy           (busy),
        .update_strobe  (update_strobe),
        .timeout_error  (timeout_error),
        .seq_state      (seq_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0][W-1:0] shift;
        int                  stop_cyc;   // cycle whose edge samples stop, -1 none
        logic [N-1:0][7:0]   en_edge;    // edge after which chain k is high, NEVER
        int                  busy_fall;  // edge after which busy is low, -1 none
        seq_state_t          end_state;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input int s0, input int s1, input int s2, input int stp,
                                input int e0, input int e1, input int e2, input int bf,
                                input seq_state_t st);
        vec_t v;
        v.shift[0]   = W'(s0);
        v.shift[1]   = W'(s1);
        v.shift[2]   = W'(s2);
        v.stop_cyc   = stp;
        v.en_edge[0] = 8'(e0);
        v.en_edge[1] = 8'(e1);
        v.en_edge[2] = 8'(e2);
        v.busy_fall  = bf;
        v.end_state  = st;
        return v;
    endfunction

    function automatic logic [N-1:0] exp_en(input vec_t v, input int c);
        logic [N-1:0] e;
        for (int k = 0; k < N; k++)
            e[k] = (v.en_edge[k] != NEVER) && (c >= int'(v.en_edge[k]));
        return e;
    endfunction

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // From RUNNING or DRAIN, stop (if needed) and pulse every period_end;
    // expect the enables to drop one edge later with a single strobe.
    task automatic drain_to_idle(input string tag, input seq_state_t st);
        if (st == RUNNING) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check({tag, " drain entry state"}, 32'(seq_state), 32'(DRAIN));
        end
        if (st != IDLE) begin
            period_end = '1;
            tick();
            period_end = '0;
            check({tag, " strobe before clear"}, 32'(update_strobe), 32'd0);
            tick();
            check({tag, " enables cleared"}, 32'(chain_enable), 32'd0);
            check({tag, " strobe on idle"}, 32'(update_strobe), 32'd1);
            check({tag, " idle state"}, 32'(seq_state), 32'(IDLE));
            check({tag, " busy low"}, 32'(busy), 32'd0);
            tick();
            check({tag, " strobe single"}, 32'(update_strobe), 32'd0);
        end
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        string tag;
        timebase_shift = v.shift;
        for (int c = 0; c <= 24; c++) begin
            start = (c == 0);
            stop  = (c == v.stop_cyc);
            tick();
            start = 1'b0;
            stop  = 1'b0;
            // Shadow registers must ignore changes after the start edge.
            if (c == 0) timebase_shift = {$urandom_range(0, 65535), $urandom_range(0, 65535),
                                          $urandom_range(0, 65535)};
            tag = $sformatf("v%0d c%0d", idx, c);
            check({tag, " enable"}, 32'(chain_enable), 32'(exp_en(v, c)));
            check({tag, " running"}, 32'(counter_running), 32'(exp_en(v, c)));
            check({tag, " busy"}, 32'(busy), 32'((v.busy_fall < 0) || (c < v.busy_fall)));
            check({tag, " strobe"}, 32'(update_strobe),
                  32'((v.end_state == IDLE) && (c == v.busy_fall)));
        end
        check($sformatf("v%0d end state", idx), 32'(seq_state), 32'(v.end_state));
        drain_to_idle($sformatf("v%0d", idx), v.end_state);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] exp_v;
        int pe_at [N];
        int strobes;

        vecs[0] = mk( 0, 10, 20, -1,  1,  11,  21, 21, RUNNING);
        vecs[1] = mk(20,  0, 20, -1, 21,   1,  21, 21, RUNNING);
        vecs[2] = mk( 5,  5,  5, -1,  6,   6,   6,  6, RUNNING);
        vecs[3] = mk( 3,  1,  2, -1,  4,   2,   3,  4, RUNNING);
        vecs[4] = mk( 0, 10, 20,  5,  1, 255, 255, -1, DRAIN);
        vecs[5] = mk( 0,  3,  4,  1, 255, 255, 255, 1, IDLE);
        vecs[6] = mk( 7,  0,  2,  3, 255,  1, 255, -1, DRAIN);

        reset          = 1'b0;
        start          = 1'b0;
        stop           = 1'b0;
        period_end     = '0;
        timebase_shift = '0;

        // Reset asserted before the first clock edge: outputs clear asynchronously.
        #2 reset = 1'b1;
        #1;
        check("reset enable", 32'(chain_enable), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset strobe", 32'(update_strobe), 32'd0);
        check("reset timeout", 32'(timeout_error), 32'd0);
        check("reset state", 32'(seq_state), 32'(IDLE));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // stop in IDLE is ignored.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("idle stop state", 32'(seq_state), 32'(IDLE));
        check("idle stop busy", 32'(busy), 32'd0);
        check("idle stop strobe", 32'(update_strobe), 32'd0);

        for (int i = 0; i < 7; i++) run_vector(i, vecs[i]);

        // Simultaneous start+stop in IDLE: start taken. Then staggered drain.
        timebase_shift = '0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("start+stop state", 32'(seq_state), 32'(STAGGER));
        check("start+stop enable", 32'(chain_enable), 32'd0);
        tick();
        check("all-zero shift state", 32'(seq_state), 32'(RUNNING));
        check("all-zero shift enable", 32'(chain_enable), 32'h7);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("running start ignored", 32'(seq_state), 32'(RUNNING));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop to drain", 32'(seq_state), 32'(DRAIN));
        pe_at[0] = 9;
        pe_at[1] = 12;
        pe_at[2] = 5;
        strobes  = 0;
        for (int c = 1; c <= 15; c++) begin
            for (int k = 0; k < N; k++) period_end[k] = (c == pe_at[k]);
            start = (c == 2);
            tick();
            period_end = '0;
            start      = 1'b0;
            for (int k = 0; k < N; k++) exp_v[k] = (c <= pe_at[k]);
            check($sformatf("drain c%0d enable", c), 32'(chain_enable), 32'(exp_v));
            check($sformatf("drain c%0d state", c), 32'(seq_state),
                  32'((c >= 13) ? IDLE : DRAIN));
            check($sformatf("drain c%0d busy", c), 32'(busy), 32'(c < 13));
            check($sformatf("drain c%0d strobe", c), 32'(update_strobe), 32'(c == 13));
            if (update_strobe) strobes++;
        end
        check("drain strobe count", 32'(strobes), 32'd1);

        // Asynchronous reset in the middle of DRAIN.
        timebase_shift = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("pre-reset state", 32'(seq_state), 32'(DRAIN));
        #3 reset = 1'b1;
        #1;
        check("mid-drain reset enable", 32'(chain_enable), 32'd0);
        check("mid-drain reset running", 32'(counter_running), 32'd0);
        check("mid-drain reset busy", 32'(busy), 32'd0);
        check("mid-drain reset strobe", 32'(update_strobe), 32'd0);
        check("mid-drain reset state", 32'(seq_state), 32'(IDLE));
        @(negedge clock);
        reset = 1'b0;
        run_vector(10, vecs[0]);

`ifdef PWM_SEQ_DRAIN_TIMEOUT_EN
        // No period_end during DRAIN: forced off after 100 cycles.
        timebase_shift = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (c == 99) begin
                check("timeout c99 enable", 32'(chain_enable), 32'h7);
                check("timeout c99 flag", 32'(timeout_error), 32'd0);
            end
        end
        check("timeout enable", 32'(chain_enable), 32'd0);
        check("timeout flag", 32'(timeout_error), 32'd1);
        check("timeout strobe", 32'(update_strobe), 32'd1);
        check("timeout state", 32'(seq_state), 32'(IDLE));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("timeout cleared on start", 32'(timeout_error), 32'd0);
        tick();
        drain_to_idle("post-timeout", RUNNING);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
